ascii_to_scancode: RTL
======================

Name: ascii_to_scancode

Overview:
- Converts one ASCII character into the AT (set 2) make/break scancode byte sequence a keyboard would send, including shift and ctrl modifier wrapping.
- Sits in front of the PS/2 device-side transmitter for keyboard emulation and closed-loop bench stimulus.
- Its output sequence decodes back to the same ASCII in the existing scancode-to-ASCII converter.

Parameters:
GAP_CYCLES, 2, idle clocks inserted after each emitted byte before the next may be offered (0 allowed).

Ports:
clock  input  1  system clock, all logic on rising edge.
reset_n  input  1  asynchronous, active-low reset.
ascii  input  8  character to encode; sampled when strobe_in=1 and busy=0.
strobe_in  input  1  request; one or more cycles high.
busy  output  1  high from acceptance until the last byte's gap ends.
scancode  output  8  current byte; valid when strobe_out=1.
strobe_out  output  1  one-cycle pulse per emitted byte.
tx_ready  input  1  downstream can accept a byte this cycle.
err  output  1  one-cycle pulse: character unmapped, nothing emitted.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, strobe_out=0, err=0, scancode=8'h00; sequence index=0, gap counter=0.
- Acceptance: in IDLE, strobe_in=1 latches ascii on that edge. State becomes LOOKUP and busy=1 from the next cycle. strobe_in while busy is ignored, not queued.
- LOOKUP (1 cycle): combinational table yields base code and class (PLAIN, SHIFT, CTRL, NONE).
  - NONE: pulse err next cycle, return to IDLE, busy=0.
  - Otherwise: build sequence and go to EMIT.
- Sequences:
  - PLAIN: code, F0, code (3 bytes).
  - SHIFT: 12, code, F0, code, F0, 12 (6 bytes).
  - CTRL: 14, code, F0, code, F0, 14 (6 bytes).
- Table, lowercase letters (PLAIN):
  - a1C b32 c21 d23 e24 f2B g34 h33 i43 j3B k42 l4B m3A
  - n31 o44 p4D q15 r2D s1B t2C u3C v2A w1D x22 y35 z1A
- Table, digits and space (PLAIN): 0:45 1:16 2:1E 3:26 4:25 5:2E 6:36 7:3D 8:3E 9:46; space 0x20:29.
- Table, punctuation (PLAIN): '-':4E '=':55 ',':41 '.':49 '/':4A ';':4C 0x27:52.
- Table, controls (PLAIN): 0x0D:5A, 0x08:66, 0x09:0D, 0x1B:76.
- Uppercase 0x41-0x5A: SHIFT, using the code of ascii+0x20.
- 0x01-0x1A except 08/09/0D: CTRL, using the code of ascii+0x60.
- Everything else is NONE: 0x00, other controls, shifted punctuation, 0x7F, and bit7=1.
- EMIT: when tx_ready=1, drive scancode=seq[index] with strobe_out=1 for exactly that cycle; index increments. While tx_ready=0, hold with strobe_out=0, no timeout.
- GAP: count GAP_CYCLES clocks (skip if 0), then:
  - back to EMIT if bytes remain;
  - else IDLE with busy=0 the following cycle.
- scancode holds its last value between strobes.
- Minimum latency: strobe_in edge N → first strobe_out at N+2 (tx_ready high).
- Back-to-back: a new strobe_in is accepted in the first cycle busy=0.
- tx_ready dropping mid-sequence: stall at the current index; no byte skipped or repeated.

Test Plan:
- ascii=0x61, tx_ready=1, GAP_CYCLES=2 → bytes 1C,F0,1C; strobes 3 clocks apart; first at N+2; busy low after last gap.
- ascii=0x41 → 12,1C,F0,1C,F0,12; feeding it into the scancode-to-ASCII converter yields 0x41.
- ascii=0x03 → 14,21,F0,21,F0,14; ascii=0x0D → 5A,F0,5A (not ctrl-wrapped).
- ascii=0x7E, and separately 0x80 → single err pulse at N+2; no strobe_out; busy=0 at N+3.
- 'A' with tx_ready low for 10 cycles after the 2nd byte → exactly 6 strobes, order intact. strobe_in pulsed mid-sequence → ignored.
- reset_n low during the 4th byte of 'A' → all outputs 0 immediately. Next request 0x62 → clean 32,F0,32.

Source files
------------

// File: rtl/ascii_to_scancode.sv
// ascii_to_scancode
// Converts one ASCII character into the AT (set 2) make/break byte sequence
// a keyboard would send, with shift/ctrl wrapping where needed.
//
// Ports:
//   clock       system clock, rising edge
//   reset_n     asynchronous active-low reset
//   ascii       character to encode, sampled on acceptance
//   strobe_in   request, accepted only while idle
//   busy        high from acceptance until the last byte's gap ends
//   scancode    current byte, valid with strobe_out, held between strobes
//   strobe_out  one-cycle pulse per emitted byte
//   tx_ready    downstream can take a byte this cycle
//   err         one-cycle pulse for an unmapped character
//
// state    | meaning
// S_IDLE   | waiting for strobe_in
// S_LOOKUP | classify latched character
// S_ERR    | unmapped character, pulse err
// S_EMIT   | offer seq[index] when tx_ready
// S_GAP    | idle clocks after an emitted byte
module ascii_to_scancode #(
    parameter int GAP_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] ascii,
    input  logic       strobe_in,
    output logic       busy,
    output logic [7:0] scancode,
    output logic       strobe_out,
    input  logic       tx_ready,
    output logic       err
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam bit GAP_EN = (GAP_CYCLES > 0);

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_ERR, S_EMIT, S_GAP} state_t;
    typedef enum logic [1:0] {C_PLAIN, C_SHIFT, C_CTRL, C_NONE} cls_t;

    state_t        r_state, w_state_next;
    cls_t          r_cls, w_cls;
    logic [7:0]    r_ascii, r_code, w_code, w_byte, r_scancode;
    logic [2:0]    r_idx, w_len;
    logic [GW-1:0] r_gap;
    logic          r_strobe, r_err;
    logic          w_accept, w_lookup, w_err_set, w_emit, w_gap_load, w_gap_dec;
    logic [8:0]    w_plain;

    // {valid, code} for the unshifted key producing character c
    function automatic logic [8:0] plain_code(input logic [7:0] c);
        case (c)
            8'h61: return {1'b1, 8'h1C};  8'h62: return {1'b1, 8'h32};
            8'h63: return {1'b1, 8'h21};  8'h64: return {1'b1, 8'h23};
            8'h65: return {1'b1, 8'h24};  8'h66: return {1'b1, 8'h2B};
            8'h67: return {1'b1, 8'h34};  8'h68: return {1'b1, 8'h33};
            8'h69: return {1'b1, 8'h43};  8'h6A: return {1'b1, 8'h3B};
            8'h6B: return {1'b1, 8'h42};  8'h6C: return {1'b1, 8'h4B};
            8'h6D: return {1'b1, 8'h3A};  8'h6E: return {1'b1, 8'h31};
            8'h6F: return {1'b1, 8'h44};  8'h70: return {1'b1, 8'h4D};
            8'h71: return {1'b1, 8'h15};  8'h72: return {1'b1, 8'h2D};
            8'h73: return {1'b1, 8'h1B};  8'h74: return {1'b1, 8'h2C};
            8'h75: return {1'b1, 8'h3C};  8'h76: return {1'b1, 8'h2A};
            8'h77: return {1'b1, 8'h1D};  8'h78: return {1'b1, 8'h22};
            8'h79: return {1'b1, 8'h35};  8'h7A: return {1'b1, 8'h1A};
            8'h30: return {1'b1, 8'h45};  8'h31: return {1'b1, 8'h16};
            8'h32: return {1'b1, 8'h1E};  8'h33: return {1'b1, 8'h26};
            8'h34: return {1'b1, 8'h25};  8'h35: return {1'b1, 8'h2E};
            8'h36: return {1'b1, 8'h36};  8'h37: return {1'b1, 8'h3D};
            8'h38: return {1'b1, 8'h3E};  8'h39: return {1'b1, 8'h46};
            8'h20: return {1'b1, 8'h29};  8'h2D: return {1'b1, 8'h4E};
            8'h3D: return {1'b1, 8'h55};  8'h2C: return {1'b1, 8'h41};
            8'h2E: return {1'b1, 8'h49};  8'h2F: return {1'b1, 8'h4A};
            8'h3B: return {1'b1, 8'h4C};  8'h27: return {1'b1, 8'h52};
            8'h0D: return {1'b1, 8'h5A};  8'h08: return {1'b1, 8'h66};
            8'h09: return {1'b1, 8'h0D};  8'h1B: return {1'b1, 8'h76};
            default: return 9'h000;
        endcase
    endfunction

    // Classification of the latched character. Uppercase and ctrl letters
    // reuse the lowercase key code; 08/09/0D have their own keys.
    always_comb begin
        w_cls = C_NONE;
        w_plain = 9'h000;
        if (r_ascii >= 8'h41 && r_ascii <= 8'h5A) begin
            w_plain = plain_code(r_ascii + 8'h20);
            w_cls = C_SHIFT;
        end else if (r_ascii >= 8'h01 && r_ascii <= 8'h1A &&
                     r_ascii != 8'h08 && r_ascii != 8'h09 && r_ascii != 8'h0D) begin
            w_plain = plain_code(r_ascii + 8'h60);
            w_cls = C_CTRL;
        end else begin
            w_plain = plain_code(r_ascii);
            w_cls = w_plain[8] ? C_PLAIN : C_NONE;
        end
        w_code = w_plain[7:0];
    end

    // Sequence byte derived from class and index rather than stored
    always_comb begin
        w_len = (r_cls == C_PLAIN) ? 3'd3 : 3'd6;
        w_byte = r_code;
        if (r_cls == C_PLAIN) begin
            if (r_idx == 3'd1) w_byte = 8'hF0;
        end else begin
            case (r_idx)
                3'd0, 3'd5: w_byte = (r_cls == C_SHIFT) ? 8'h12 : 8'h14;
                3'd2, 3'd4: w_byte = 8'hF0;
                default:    w_byte = r_code;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept = 1'b0;
        w_lookup = 1'b0;
        w_err_set = 1'b0;
        w_emit = 1'b0;
        w_gap_load = 1'b0;
        w_gap_dec = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (strobe_in) begin
                    w_accept = 1'b1;
                    w_state_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                w_lookup = 1'b1;
                w_state_next = (w_cls == C_NONE) ? S_ERR : S_EMIT;
            end
            S_ERR: begin
                w_err_set = 1'b1;
                w_state_next = S_IDLE;
            end
            S_EMIT: begin
                if (tx_ready) begin
                    w_emit = 1'b1;
                    if (GAP_EN) begin
                        w_gap_load = 1'b1;
                        w_state_next = S_GAP;
                    end else if (r_idx == w_len - 3'd1) begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                // r_idx already points past the byte just sent
                if (r_gap == GW'(1)) begin
                    w_state_next = (r_idx == w_len) ? S_IDLE : S_EMIT;
                end else begin
                    w_gap_dec = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ascii    <= 8'h00;
            r_code     <= 8'h00;
            r_cls      <= C_NONE;
            r_idx      <= 3'd0;
            r_gap      <= '0;
            r_scancode <= 8'h00;
            r_strobe   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_strobe <= w_emit;
            r_err    <= w_err_set;
            if (w_accept) r_ascii <= ascii;
            if (w_lookup) begin
                r_code <= w_code;
                r_cls  <= w_cls;
                r_idx  <= 3'd0;
            end
            if (w_emit) begin
                r_scancode <= w_byte;
                r_idx      <= r_idx + 3'd1;
            end
            if (w_gap_load)     r_gap <= GW'(GAP_CYCLES);
            else if (w_gap_dec) r_gap <= r_gap - GW'(1);
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign scancode   = r_scancode;
    assign strobe_out = r_strobe;
    assign err        = r_err;

endmodule
